multicycle_controller: RTL and testbench

//  Multi-cycle RV32I main controller: FSM sequencing FETCH/DECODE/EXEC/MEM/WB over a shared

---
 rtl/riscv_ctrl_pkg.sv | 47 ++++
 rtl/multicycle_controller_if.sv | 31 +++
 rtl/mem_wait_timer.sv | 32 +++
 rtl/multicycle_controller.sv | 172 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared RV32I controller definitions: opcodes, FSM state encoding and datapath mux codes.
package riscv_ctrl_pkg;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpAluR   = 7'b0110011;
  localparam logic [6:0] OpAluI   = 7'b0010011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StTrap
  } ctrl_state_e;

  localparam logic [1:0] AluOpAdd    = 2'b00;
  localparam logic [1:0] AluOpBranch = 2'b01;
  localparam logic [1:0] AluOpFunct  = 2'b10;

  localparam logic [1:0] PcSrcSeq  = 2'b00;
  localparam logic [1:0] PcSrcAlu  = 2'b01;
  localparam logic [1:0] PcSrcJalr = 2'b10;

  localparam logic [1:0] SrcARs1  = 2'b00;
  localparam logic [1:0] SrcAPc   = 2'b01;
  localparam logic [1:0] SrcAZero = 2'b10;

  localparam logic [1:0] MemToRegAlu = 2'b00;
  localparam logic [1:0] MemToRegMem = 2'b01;
  localparam logic [1:0] MemToRegPc4 = 2'b10;

  function automatic logic is_legal_op(input logic [6:0] op);
    case (op)
      OpLoad, OpStore, OpAluR, OpAluI, OpLui, OpAuipc, OpBranch, OpJal, OpJalr: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> IR/datapath bundle. The controller drives the master side.
interface multicycle_controller_if;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       branch_taken;
  logic       PCWrite;
  logic [1:0] PCSrc;
  logic       IRWrite;
  logic       IorD;
  logic [1:0] ALUSrcA;
  logic       ALUSrc;
  logic [1:0] ALUOp;
  logic       MemRead;
  logic       MemWrite;
  logic       RegWrite;
  logic [1:0] MemToReg;
  logic       illegal_op;
  logic       mem_timeout;

  modport master (
    input  opcode, mem_ready, branch_taken,
    output PCWrite, PCSrc, IRWrite, IorD, ALUSrcA, ALUSrc, ALUOp,
    output MemRead, MemWrite, RegWrite, MemToReg, illegal_op, mem_timeout
  );

  modport slave (
    output opcode, mem_ready, branch_taken,
    input  PCWrite, PCSrc, IRWrite, IorD, ALUSrcA, ALUSrc, ALUOp,
    input  MemRead, MemWrite, RegWrite, MemToReg, illegal_op, mem_timeout
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Saturating wait counter; expired flags the cycle in which the wait reaches MEM_TIMEOUT.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(MEM_TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(MEM_TIMEOUT - 1);

  logic [CntW-1:0] count_q;

  // Count waiting cycles, hold at the maximum instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != CntMax)) begin
      count_q <= count_q + CntW'(1);
    end
  end

  // The current waiting cycle is the MEM_TIMEOUT-th one (or later when saturated).
  assign expired = enable && (count_q >= CntLast);

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I main controller: FETCH/DECODE/EXEC/MEM/WB sequencing with trap handling.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter bit          TRAP_EN     = 1'b1
) (
  input logic                     clk,
  input logic                     rst_n,
  multicycle_controller_if.master bus
);

  ctrl_state_e state_q;
  logic [6:0]  opcode_q;
  logic        illegal_q, timeout_q;
  logic        waiting, wait_en, expired;

  logic       pc_write, ir_write, ior_d, alu_src, mem_read, mem_write, reg_write;
  logic [1:0] pc_src, alu_src_a, alu_op, mem_to_reg;

  assign waiting = (state_q == StFetch) || (state_q == StMem);
  assign wait_en = waiting && !bus.mem_ready;

  // Any cycle not spent waiting restarts the count, so each FETCH/MEM entry starts from zero.
  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!wait_en),
    .enable (wait_en),
    .expired(expired)
  );

  // State sequencing, opcode latch and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      opcode_q  <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: state_q <= StFetch;
        StFetch: begin
          if (bus.mem_ready) begin
            state_q <= StDecode;
          end else if (TRAP_EN && expired) begin
            timeout_q <= 1'b1;
            state_q   <= StTrap;
          end
        end
        StDecode: begin
          opcode_q <= bus.opcode;
          if (is_legal_op(bus.opcode)) begin
            state_q <= StExec;
          end else if (TRAP_EN) begin
            illegal_q <= 1'b1;
            state_q   <= StTrap;
          end else begin
            state_q <= StFetch;
          end
        end
        StExec: begin
          case (opcode_q)
            OpLoad, OpStore: state_q <= StMem;
            OpBranch:        state_q <= StFetch;
            default:         state_q <= StWb;
          endcase
        end
        StMem: begin
          if (bus.mem_ready) begin
            state_q <= (opcode_q == OpLoad) ? StWb : StFetch;
          end else if (TRAP_EN && expired) begin
            timeout_q <= 1'b1;
            state_q   <= StTrap;
          end
        end
        StWb:    state_q <= StFetch;
        StTrap:  state_q <= StTrap;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Control decode from state and latched opcode; only FETCH completion and branch PCWrite
  // look at live inputs.
  always_comb begin
    pc_write   = 1'b0;
    pc_src     = PcSrcSeq;
    ir_write   = 1'b0;
    ior_d      = 1'b0;
    alu_src_a  = SrcARs1;
    alu_src    = 1'b0;
    alu_op     = AluOpAdd;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = MemToRegAlu;
    unique case (state_q)
      StFetch: begin
        mem_read = 1'b1;
        ir_write = bus.mem_ready;
        pc_write = bus.mem_ready;
      end
      StExec: begin
        case (opcode_q)
          OpAluR: alu_op = AluOpFunct;
          OpAluI: begin
            alu_src = 1'b1;
            alu_op  = AluOpFunct;
          end
          OpLui: begin
            alu_src_a = SrcAZero;
            alu_src   = 1'b1;
          end
          OpAuipc: begin
            alu_src_a = SrcAPc;
            alu_src   = 1'b1;
          end
          OpLoad, OpStore: alu_src = 1'b1;
          OpBranch: begin
            alu_op   = AluOpBranch;
            pc_write = bus.branch_taken;
            pc_src   = PcSrcAlu;
          end
          OpJal: begin
            alu_src_a = SrcAPc;
            alu_src   = 1'b1;
            pc_write  = 1'b1;
            pc_src    = PcSrcAlu;
          end
          OpJalr: begin
            alu_src  = 1'b1;
            pc_write = 1'b1;
            pc_src   = PcSrcJalr;
          end
          default: ;
        endcase
      end
      StMem: begin
        ior_d     = 1'b1;
        mem_read  = (opcode_q == OpLoad);
        mem_write = (opcode_q == OpStore);
      end
      StWb: begin
        reg_write = 1'b1;
        if (opcode_q == OpLoad) begin
          mem_to_reg = MemToRegMem;
        end else if ((opcode_q == OpJal) || (opcode_q == OpJalr)) begin
          mem_to_reg = MemToRegPc4;
        end
      end
      default: ;
    endcase
  end

  assign bus.PCWrite     = pc_write;
  assign bus.PCSrc       = pc_src;
  assign bus.IRWrite     = ir_write;
  assign bus.IorD        = ior_d;
  assign bus.ALUSrcA     = alu_src_a;
  assign bus.ALUSrc      = alu_src;
  assign bus.ALUOp       = alu_op;
  assign bus.MemRead     = mem_read;
  assign bus.MemWrite    = mem_write;
  assign bus.RegWrite    = reg_write;
  assign bus.MemToReg    = mem_to_reg;
  assign bus.illegal_op  = illegal_q;
  assign bus.mem_timeout = timeout_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-instruction control tables plus corner sequences.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // {PCWrite, PCSrc, IRWrite, IorD, ALUSrcA, ALUSrc, ALUOp, MemRead, MemWrite, RegWrite, MemToReg}
  logic [14:0] ctl;
  logic [1:0]  flags;
  assign ctl = {bus.PCWrite, bus.PCSrc, bus.IRWrite, bus.IorD, bus.ALUSrcA, bus.ALUSrc,
                bus.ALUOp, bus.MemRead, bus.MemWrite, bus.RegWrite, bus.MemToReg};
  assign flags = {bus.illegal_op, bus.mem_timeout};

  int checks = 0;
  int errors = 0;

  function automatic logic [14:0] mk(input logic pcw, input logic [1:0] pcsrc, input logic irw,
                                     input logic iord, input logic [1:0] asa, input logic alub,
                                     input logic [1:0] aluop, input logic mr, input logic mw,
                                     input logic rw, input logic [1:0] m2r);
    return {pcw, pcsrc, irw, iord, asa, alub, aluop, mr, mw, rw, m2r};
  endfunction

  task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  typedef struct {
    string          name;
    logic [6:0]     opcode;
    logic           bt;
    int             cpi;
    logic [4:0][14:0] exp;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  logic [14:0] fetch_rdy, fetch_wait, wb_alu, wb_pc4;

  task automatic set_vec(input int idx, input string name, input logic [6:0] op, input logic bt,
                         input int cpi, input logic [14:0] e2, input logic [14:0] e3,
                         input logic [14:0] e4);
    vecs[idx].name   = name;
    vecs[idx].opcode = op;
    vecs[idx].bt     = bt;
    vecs[idx].cpi    = cpi;
    vecs[idx].exp[0] = fetch_rdy;
    vecs[idx].exp[1] = '0;
    vecs[idx].exp[2] = e2;
    vecs[idx].exp[3] = e3;
    vecs[idx].exp[4] = e4;
  endtask

  task automatic reset_to_fetch();
    rst_n = 1'b0;
    #1;
    check("reset_ctl", ctl, '0);
    check("reset_flags", {13'd0, flags}, '0);
    tick();
    rst_n = 1'b1;
    #1;
    check("idle_ctl", ctl, '0);
    tick();
  endtask

  initial begin
    fetch_rdy  = mk(1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    fetch_wait = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    wb_alu     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    wb_pc4     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
    set_vec(0, "add", 7'b0110011, 1'b1, 4, mk(0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0), wb_alu, '0);
    set_vec(1, "addi", 7'b0010011, 1'b0, 4, mk(0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0), wb_alu, '0);
    set_vec(2, "lui", 7'b0110111, 1'b0, 4, mk(0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0), wb_alu, '0);
    set_vec(3, "auipc", 7'b0010111, 1'b0, 4, mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0), wb_alu, '0);
    set_vec(4, "lw", 7'b0000011, 1'b0, 5, mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0),
            mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    set_vec(5, "sw", 7'b0100011, 1'b0, 4, mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0),
            mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0), '0);
    set_vec(6, "beq_taken", 7'b1100011, 1'b1, 3, mk(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0), '0, '0);
    set_vec(7, "beq_not", 7'b1100011, 1'b0, 3, mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0), '0, '0);
    set_vec(8, "jal", 7'b1101111, 1'b0, 4, mk(1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0), wb_pc4, '0);
    set_vec(9, "jalr", 7'b1100111, 1'b0, 4, mk(1, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0), wb_pc4, '0);

    bus.opcode       = 7'b0;
    bus.mem_ready    = 1'b0;
    bus.branch_taken = 1'b0;
    tick();
    reset_to_fetch();

    // Zero-wait instruction table; opcode is scrambled after DECODE to prove it is latched.
    for (int n = 0; n < NV; n++) begin
      for (int i = 0; i < vecs[n].cpi; i++) begin
        bus.opcode       = (i <= 1) ? vecs[n].opcode : 7'h7f;
        bus.branch_taken = vecs[n].bt;
        bus.mem_ready    = 1'b1;
        #1;
        check($sformatf("%s_cycle%0d", vecs[n].name, i), ctl, vecs[n].exp[i]);
        tick();
      end
    end

    // Load with three wait cycles in MEM.
    bus.branch_taken = 1'b0;
    bus.opcode       = 7'b0000011;
    bus.mem_ready    = 1'b1;
    #1;
    check("refetch", ctl, fetch_rdy);
    tick();
    #1;
    check("lw_wait_decode", ctl, '0);
    tick();
    #1;
    check("lw_wait_exec", ctl, mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tick();
    for (int w = 0; w < 4; w++) begin
      bus.mem_ready = (w == 3);
      #1;
      check($sformatf("lw_mem%0d", w), ctl, mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0));
      tick();
    end
    bus.mem_ready = 1'b0;
    #1;
    check("lw_wait_wb", ctl, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    tick();

    // Store stalled in MEM, then reset aborts it.
    bus.opcode    = 7'b0100011;
    bus.mem_ready = 1'b1;
    #1;
    check("sw_fetch", ctl, fetch_rdy);
    tick();
    tick();
    tick();
    bus.mem_ready = 1'b0;
    #1;
    check("sw_mem_stall", ctl, mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
    reset_to_fetch();
    bus.mem_ready = 1'b0;
    #1;
    check("fetch_after_reset", ctl, fetch_wait);

    // mem_ready on the 16th waiting cycle wins over the timeout.
    bus.opcode = 7'b0110011;
    for (int k = 1; k <= 16; k++) begin
      bus.mem_ready = (k == 16);
      #1;
      check($sformatf("late_ready%0d", k), ctl, (k == 16) ? fetch_rdy : fetch_wait);
      tick();
    end
    #1;
    check("late_ready_decode", ctl, '0);
    check("late_ready_flags", {13'd0, flags}, '0);

    // Sixteen cycles without mem_ready trap with mem_timeout.
    reset_to_fetch();
    for (int k = 1; k <= 16; k++) begin
      bus.mem_ready = 1'b0;
      #1;
      check($sformatf("timeout_wait%0d", k), ctl, fetch_wait);
      check($sformatf("timeout_flag%0d", k), {13'd0, flags}, '0);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      bus.mem_ready = 1'b1;
      #1;
      check($sformatf("timeout_trap%0d", k), ctl, '0);
      check($sformatf("timeout_trap_flags%0d", k), {13'd0, flags}, 15'd1);
      tick();
    end

    // Illegal opcode traps and stays trapped.
    reset_to_fetch();
    bus.opcode    = 7'b1111111;
    bus.mem_ready = 1'b1;
    #1;
    check("illegal_fetch", ctl, fetch_rdy);
    tick();
    #1;
    check("illegal_decode_flags", {13'd0, flags}, '0);
    tick();
    for (int k = 0; k < 4; k++) begin
      bus.opcode = 7'b0110011;
      #1;
      check($sformatf("illegal_trap%0d", k), ctl, '0);
      check($sformatf("illegal_flags%0d", k), {13'd0, flags}, 15'd2);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
